sram_access_target: RTL and testbench

SRAM responder: accepts `sram_access_req` transactions, performs them on an internal 64-bit-wide synchronous memory, and returns `sram_access_resp` with the request id and read data. It is the far end of the SRAM access interface driven by APB-to-SRAM bridge targets and other SRAM initiators. Access requires one cycle, with optional compiled-in wait states before acknowledgment.

---
 rtl/sram_access_target.sv | 113 +++++++++++
 tb/tb_sram_access_target.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sram_access_target.sv
// SRAM responder: performs sram_access_req transactions on an internal 64-bit memory and returns a one-cycle response.
// Optional wait-state FSM gating ack is compiled in with SRAM_ACCESS_TARGET_WAIT_EN.
module sram_access_target #(
    parameter int log2_depth  = 10,
    parameter int wait_cycles = 2
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic        sram_access_req__valid,
    input  logic [3:0]  sram_access_req__id,
    input  logic        sram_access_req__read_not_write,
    input  logic [7:0]  sram_access_req__byte_enable,
    input  logic [31:0] sram_access_req__address,
    input  logic [63:0] sram_access_req__write_data,
    output logic        sram_access_resp__ack,
    output logic        sram_access_resp__valid,
    output logic [3:0]  sram_access_resp__id,
    output logic [63:0] sram_access_resp__data
);
    localparam int depth = 1 << log2_depth;

    logic [63:0]           mem [depth];
    logic [63:0]           rd_word;
    logic [log2_depth-1:0] idx;
    logic                  accept;
    logic                  resp_is_read;

    // Upper address bits are deliberately ignored so accesses wrap.
    logic unused_bits;
    assign unused_bits = ^{sram_access_req__address[31:log2_depth], 4'(wait_cycles)};

    assign idx    = sram_access_req__address[log2_depth-1:0];
    assign accept = sram_access_req__valid && sram_access_resp__ack;

`ifdef SRAM_ACCESS_TARGET_WAIT_EN
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    localparam logic [3:0] count_init = 4'(wait_cycles - 1);

    state_t     state;
    logic [3:0] count;

    always_comb begin
        sram_access_resp__ack = 1'b0;
        case (state)
            ST_IDLE: sram_access_resp__ack = sram_access_req__valid && (wait_cycles == 0);
            ST_WAIT: sram_access_resp__ack = sram_access_req__valid && (count == 4'd0);
            default: sram_access_resp__ack = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            count <= 4'd0;
        end else if (clk__enable) begin
            case (state)
                ST_IDLE: begin
                    if (sram_access_req__valid && wait_cycles != 0) begin
                        count <= count_init;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Dropping valid mid-wait abandons the request without an access.
                    if (!sram_access_req__valid) begin
                        state <= ST_IDLE;
                        count <= 4'd0;
                    end else if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign sram_access_resp__ack = sram_access_req__valid;
`endif

    // Memory array has no reset so it maps onto a plain synchronous RAM.
    always_ff @(posedge clk) begin
        if (clk__enable && accept) begin
            if (sram_access_req__read_not_write) begin
                rd_word <= mem[idx];
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (sram_access_req__byte_enable[i])
                        mem[idx][8*i +: 8] <= sram_access_req__write_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_access_resp__valid <= 1'b0;
            sram_access_resp__id    <= 4'h0;
            resp_is_read            <= 1'b0;
        end else if (clk__enable) begin
            sram_access_resp__valid <= accept;
            resp_is_read            <= accept && sram_access_req__read_not_write;
            if (accept)
                sram_access_resp__id <= sram_access_req__id;
        end
    end

    // rd_word is unreset; the registered read flag masks it to zero otherwise.
    assign sram_access_resp__data = resp_is_read ? rd_word : 64'h0;

endmodule

// File: tb/tb_sram_access_target.sv
// Randomized and directed bench for sram_access_target against a word-array reference model.
module tb_sram_access_target;
    localparam int W_CFG = 2;
`ifdef SRAM_ACCESS_TARGET_WAIT_EN
    localparam int EXP_W = W_CFG;
`else
    localparam int EXP_W = 0;
`endif

    logic        clk = 1'b0;
    logic        clk__enable = 1'b1;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_id = 4'h0;
    logic        req_rnw = 1'b0;
    logic [7:0]  req_be = 8'h0;
    logic [31:0] req_addr = 32'h0;
    logic [63:0] req_wd = 64'h0;
    logic        ack;
    logic        resp_valid;
    logic [3:0]  resp_id;
    logic [63:0] resp_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [63:0] mref [1024];

    sram_access_target #(.log2_depth(10), .wait_cycles(W_CFG)) dut (
        .clk(clk),
        .clk__enable(clk__enable),
        .reset_n(reset_n),
        .sram_access_req__valid(req_valid),
        .sram_access_req__id(req_id),
        .sram_access_req__read_not_write(req_rnw),
        .sram_access_req__byte_enable(req_be),
        .sram_access_req__address(req_addr),
        .sram_access_req__write_data(req_wd),
        .sram_access_resp__ack(ack),
        .sram_access_resp__valid(resp_valid),
        .sram_access_resp__id(resp_id),
        .sram_access_resp__data(resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request starting at a falling edge, waits (bounded) for ack,
    // then checks the response pulse at the falling edge after the accept.
    task automatic send(input logic rnw, input logic [3:0] id, input logic [7:0] be,
                        input logic [31:0] addr, input logic [63:0] wd, input bit hold,
                        input string tag, output int rcyc);
        int waits;
        logic [63:0] exp_data;
        req_valid = 1'b1; req_rnw = rnw; req_id = id; req_be = be; req_addr = addr; req_wd = wd;
        waits = 0;
        rcyc = -1;
        #1;
        while (!ack && waits < 40) begin
            @(posedge clk); @(negedge clk); #1;
            waits++;
        end
        chk({tag, "_waits"}, 64'(waits), 64'(EXP_W));
        if (!ack) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_data = rnw ? mref[addr[9:0]] : 64'h0;
        if (!rnw)
            for (int b = 0; b < 8; b++)
                if (be[b]) mref[addr[9:0]][8*b +: 8] = wd[8*b +: 8];
        @(negedge clk);
        rcyc = cyc;
        chk({tag, "_vld"}, 64'(resp_valid), 64'd1);
        chk({tag, "_id"}, 64'(resp_id), 64'(id));
        chk({tag, "_data"}, resp_data, exp_data);
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        int r0, r1, r2, r3, t0;
        logic [31:0] a;

        // reset state
        #12;
        chk("rst_vld", 64'(resp_valid), 64'd0);
        chk("rst_id", 64'(resp_id), 64'd0);
        chk("rst_data", resp_data, 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);

        // full write then read back-to-back, partial write, wrap-around
        send(1'b0, 4'd3, 8'hff, 32'h5, 64'h0123456789abcdef, 1'b1, "wr_full", r0);
        send(1'b1, 4'd7, 8'h00, 32'h5, 64'h0, 1'b0, "rd_full", r1);
        chk("rd_after_wr_gap", 64'(r1 - r0), 64'(EXP_W + 1));
        chk("rd_full_val", mref[5], 64'h0123456789abcdef);
        send(1'b0, 4'd1, 8'h0f, 32'h5, 64'hffffffffffffffff, 1'b1, "wr_part", r0);
        send(1'b1, 4'd2, 8'hff, 32'h5, 64'h0, 1'b0, "rd_part", r1);
        chk("rd_part_val", mref[5], 64'h01234567ffffffff);
        send(1'b0, 4'd4, 8'hff, 32'h400, 64'h1, 1'b1, "wr_wrap", r0);
        send(1'b1, 4'd5, 8'hff, 32'h0, 64'h0, 1'b0, "rd_wrap", r1);
        send(1'b0, 4'd6, 8'h00, 32'h0, 64'hdeadbeefdeadbeef, 1'b0, "wr_be0", r0);
        send(1'b1, 4'd8, 8'h00, 32'h0, 64'h0, 1'b0, "rd_be0", r1);
        @(negedge clk);
        chk("pulse_end", 64'(resp_valid), 64'd0);

        // four back-to-back requests
        send(1'b0, 4'h9, 8'hff, 32'h20, 64'h1111, 1'b1, "b2b0", r0);
        send(1'b0, 4'ha, 8'hff, 32'h21, 64'h2222, 1'b1, "b2b1", r1);
        send(1'b1, 4'hb, 8'hff, 32'h20, 64'h0, 1'b1, "b2b2", r2);
        send(1'b1, 4'hc, 8'hff, 32'h21, 64'h0, 1'b0, "b2b3", r3);
        chk("b2b_gap1", 64'(r1 - r0), 64'(EXP_W + 1));
        chk("b2b_gap2", 64'(r2 - r1), 64'(EXP_W + 1));
        chk("b2b_gap3", 64'(r3 - r2), 64'(EXP_W + 1));
        @(negedge clk);

        // clock enable gated low for 3 cycles with a request pending
        clk__enable = 1'b0;
        req_valid = 1'b1; req_rnw = 1'b1; req_id = 4'hd; req_addr = 32'h5;
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("cen_no_resp", 64'(resp_valid), 64'd0);
        end
        clk__enable = 1'b1;
        send(1'b1, 4'hd, 8'h00, 32'h5, 64'h0, 1'b0, "cen_rd", r0);
        chk("cen_delay", 64'(r0 - t0), 64'(3 + EXP_W + 1));
        @(negedge clk);

        // asynchronous reset mid-response keeps memory
        send(1'b0, 4'he, 8'hff, 32'h9, 64'hcafef00d12345678, 1'b1, "wr_rst", r0);
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_vld", 64'(resp_valid), 64'd0);
        chk("midrst_id", 64'(resp_id), 64'd0);
        chk("midrst_data", resp_data, 64'd0);
        chk("midrst_ack", 64'(ack), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        send(1'b1, 4'hf, 8'h00, 32'h9, 64'h0, 1'b0, "rd_rst", r0);
        @(negedge clk);

        // randomized traffic over a prefilled window, with random upper address bits
        for (int i = 0; i < 32; i++) begin
            a = {$urandom_range(0, 4194303), 10'(i)};
            send(1'b0, 4'($urandom), 8'hff, a, {$urandom, $urandom}, 1'b1, "fill", r0);
        end
        for (int i = 0; i < 80; i++) begin
            a = {$urandom_range(0, 4194303), 10'($urandom_range(0, 31))};
            send(1'($urandom), 4'($urandom), 8'($urandom), a, {$urandom, $urandom},
                 1'($urandom), "rnd", r0);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
